rx_word_framer: RTL and testbench
=================================

# rx_word_framer

Receive-side word framer placed directly upstream of the decryption stage. It takes the demodulated serial bitstream, finds frame alignment by hunting for a fixed sync word, and assembles payload bits into `N`-bit words. Each word is presented on a valid/ready output that feeds the decryptor's ciphertext input. It also tracks lock and drops back to hunting after repeated sync misses.

## Interface
- `N`, 24: word width in bits; must match the decryptor bus width.
- `SYNC_WORD`, 24'hB4C3A5: sync pattern, MSB received first; must be nonzero.
- `FRAME_WORDS`, 4: payload words per frame (1–255).
- `MISS_MAX`, 3: consecutive sync misses that cause loss of lock (1–7).

- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `bit_in`  in  1  serial data bit
- `bit_valid`  in  1  `bit_in` is accepted this cycle; may be high every cycle
- `word_out`  out  N  assembled payload word, first-received bit in MSB
- `word_valid`  out  1  `word_out` holds an unconsumed word
- `word_ready`  in  1  consumer accepts `word_out` when it is high together with `word_valid`
- `locked`  out  1  framer is aligned
- `frame_ok`  out  1  one-cycle pulse when a sync word is confirmed at the expected position
- `overflow`  out  1  sticky flag: a payload word was dropped

## Operation
- Shift register `sr[N-1:0]`: on `bit_valid`, `sr <= {sr[N-2:0], bit_in}`. Reset value is 0.
- The states below are cleared by reset and also on each HUNT re-entry. Counters: `bit_cnt` (0..N-1), `word_cnt` (0..FRAME_WORDS-1), `miss_cnt` (0..MISS_MAX-1).
- State HUNT:
  - Each accepted bit, compare the post-shift `sr` with `SYNC_WORD`.
  - On a match, go to PAYLOAD with `bit_cnt=0` and `word_cnt=0`.
  - This initial match does not pulse `frame_ok`.
- State PAYLOAD:
  - Each accepted bit increments `bit_cnt`.
  - On the Nth bit, the post-shift `sr` forms a complete word, and `bit_cnt` wraps to 0.
  - After word number FRAME_WORDS, go to CHECK.
- State CHECK:
  - Collect N bits, then compare with `SYNC_WORD`.
  - Match: `miss_cnt=0`, pulse `frame_ok`, go to PAYLOAD.
  - Mismatch with `miss_cnt+1 < MISS_MAX`: increment `miss_cnt` and go to PAYLOAD (flywheel; alignment is kept).
  - Mismatch otherwise: go to HUNT.
- `locked` = 1 in PAYLOAD and CHECK, 0 in HUNT. It is registered from the state.
- Output register, one entry:
  - A completed word loads `word_out` and sets `word_valid` when the register is empty, or when `word_ready` is high in the same cycle.
  - If `word_valid && !word_ready` when a word completes, the new word is discarded, the old word is held, and `overflow` is set.
  - A handshake with no new word clears `word_valid`.
- `overflow` is cleared only by reset.
- Words already in the output register survive loss of lock.

## Timing
- Reset values: `word_out=0`, `word_valid=0`, `locked=0`, `frame_ok=0`, `overflow=0`, state=HUNT.
- Latency: `word_valid` rises on the clock edge that accepts the last bit of the word, and is visible the following cycle.
- `locked` rises on the edge that accepts the last sync bit.
- `frame_ok` is high for exactly the one cycle after the edge that accepts the last bit of a matching sync word.
- Cycles with `bit_valid=0` hold all counters and the state.
- Reset asserted mid-frame returns the block to HUNT immediately and discards any partial word.
- Sync is only detected in HUNT. Sync patterns appearing inside payload are ignored.

## Configuration
- `RX_FRAMER_STATS_EN` defined:
  - Adds outputs `frame_cnt[15:0]`, which counts `frame_ok` pulses.
  - Adds `loss_cnt[15:0]`, which counts CHECK→HUNT transitions.
  - Both counters reset to 0 and saturate at 16'hFFFF.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

## Structure
- Shared package `rx_pkg`:
  - State enum `rx_state_t` {HUNT, PAYLOAD, CHECK}.
  - Default `N` and `SYNC_WORD` constants, shared with the decryptor so the widths cannot diverge.
- Sub-module `rx_out_reg`: the single-entry valid/ready holding register with overflow detection. It is reusable on the decryptor output.

## Test plan
Defaults: `N=24`, `SYNC=24'hB4C3A5`, `FRAME_WORDS=4`, `MISS_MAX=3`.
- Reset then idle: `rst` low, then high, with no bits → all outputs 0, `locked=0`.
- Acquisition: 7 random bits, then SYNC, then words 24'h000001, 24'h123456, 24'hFFFFFF, 24'hABCDEF → `locked` rises after the sync; four words are output in order, each 1 cycle after its last bit; `frame_ok` stays 0.
- Steady state: the same frame is repeated twice with `word_ready` held high → two `frame_ok` pulses and 8 further words, no `overflow`.
- Backpressure: `word_ready=0` across two word completions → the first word is held, the second is dropped, `overflow=1` (sticky after `word_ready` returns high).
- Loss of lock: after lock, 3 frames with sync replaced by 24'h000000 → the first two are flywheeled (their words are still output); `locked` falls after the 24th bit of the third bad sync; payload words then produce no output until a new SYNC is found.
- Mid-frame reset: `rst` pulsed low after 10 payload bits → `word_valid=0`, `locked=0`, and reacquisition on the next SYNC is correct.

Source files
------------

// File: rtl/rx_pkg.sv
// Shared receive-path definitions.
// Holds the default word width and sync pattern, which the decryptor also uses
// so the two bus widths cannot drift apart. Also holds the framer state type
// and a saturating counter helper.
// No ports.

package rx_pkg;

   localparam int          N_DEFAULT    = 24;
   localparam logic [23:0] SYNC_DEFAULT = 24'hB4C3A5;

   typedef enum logic [1:0] {
      HUNT,
      PAYLOAD,
      CHECK
   } rx_state_t;

   // 16-bit increment that sticks at all-ones instead of wrapping
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/rx_word_framer_if.sv
// Serial-in / word-out bus of the receive framer.
// Signals:
//   bit_in, bit_valid : serial bit stream into the framer
//   word_out, word_valid, word_ready : valid/ready word stream out of the framer
// Modports:
//   master : the framer (consumes bits, produces words)
//   slave  : the environment (produces bits, consumes words)

interface rx_word_framer_if
   import rx_pkg::*;
#(
   parameter int N = N_DEFAULT
) ();

   logic         bit_in;
   logic         bit_valid;
   logic [N-1:0] word_out;
   logic         word_valid;
   logic         word_ready;

   modport master (
      input  bit_in,
      input  bit_valid,
      input  word_ready,
      output word_out,
      output word_valid
   );

   modport slave (
      output bit_in,
      output bit_valid,
      output word_ready,
      input  word_out,
      input  word_valid
   );

endinterface

// File: rtl/rx_out_reg.sv
// Single-entry valid/ready holding register with overflow detection.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   load, data_in   : a new word is offered this cycle
//   ready           : downstream accepts data_out when valid is high
//   data_out, valid : held word and its valid flag
//   overflow        : sticky, set when an offered word had to be dropped
// Also intended for reuse on the decryptor output.

module rx_out_reg
   import rx_pkg::*;
#(
   parameter int N = N_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [N-1:0] data_in,
   input  logic         ready,
   output logic [N-1:0] data_out,
   output logic         valid,
   output logic         overflow
);

   // A new word replaces the held one only if the slot is free or is being
   // drained in the same cycle; otherwise the newcomer is lost and flagged.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_out <= '0;
         valid    <= 1'b0;
         overflow <= 1'b0;
      end else if (load) begin
         if (!valid || ready) begin
            data_out <= data_in;
            valid    <= 1'b1;
         end else begin
            overflow <= 1'b1;
         end
      end else if (valid && ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/rx_word_framer.sv
// Receive word framer: hunts for a sync word in the serial stream, then cuts
// the following payload into N-bit words (first bit in MSB) and hands them to
// the decryptor through a one-entry valid/ready register. Lock is kept across
// up to MISS_MAX-1 consecutive bad sync words (flywheel).
// Ports:
//   clk, rst  : clock, asynchronous active-low reset
//   bus       : rx_word_framer_if.master (bit input, word output handshake)
//   locked    : aligned (PAYLOAD or CHECK)
//   frame_ok  : one-cycle pulse per confirmed sync word
//   overflow  : sticky, a payload word was dropped
// Optional build macro RX_FRAMER_STATS_EN adds frame_cnt (frame_ok pulses) and
// loss_cnt (lock losses), both saturating 16-bit counters.

module rx_word_framer
   import rx_pkg::*;
#(
   parameter int         N           = N_DEFAULT,
   parameter logic [N-1:0] SYNC_WORD = N'(SYNC_DEFAULT),
   parameter int         FRAME_WORDS = 4,
   parameter int         MISS_MAX    = 3
) (
   input  logic clk,
   input  logic rst,
   rx_word_framer_if.master bus,
   output logic locked,
   output logic frame_ok,
   output logic overflow
`ifdef RX_FRAMER_STATS_EN
   ,
   output logic [15:0] frame_cnt,
   output logic [15:0] loss_cnt
`endif
);

   localparam int             BW         = $clog2(N);
   localparam logic [BW-1:0]  LAST_BIT   = BW'(N - 1);
   localparam logic [7:0]     LAST_WORD  = 8'(FRAME_WORDS - 1);
   localparam logic [3:0]     MISS_LIMIT = 4'(MISS_MAX);

   rx_state_t     state;
   logic [N-1:0]  sr;
   logic [BW-1:0] bit_cnt;
   logic [7:0]    word_cnt;
   logic [2:0]    miss_cnt;

   logic [N-1:0]  sr_next;
   logic          sync_hit;
   logic          word_done;
   logic          check_done;
   logic          miss_room;

   // Decisions are made on the shift register as it will look after this bit.
   assign sr_next    = {sr[N-2:0], bus.bit_in};
   assign sync_hit   = (sr_next == SYNC_WORD);
   assign word_done  = bus.bit_valid && (state == PAYLOAD) && (bit_cnt == LAST_BIT);
   assign check_done = bus.bit_valid && (state == CHECK) && (bit_cnt == LAST_BIT);
   assign miss_room  = (({1'b0, miss_cnt} + 4'd1) < MISS_LIMIT);

   // Framing FSM. locked is registered alongside the state so it changes on
   // the same edge as the transition. Idle cycles (no bit_valid) freeze it all.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= HUNT;
         sr       <= '0;
         bit_cnt  <= '0;
         word_cnt <= '0;
         miss_cnt <= '0;
         locked   <= 1'b0;
         frame_ok <= 1'b0;
      end else begin
         frame_ok <= 1'b0;
         if (bus.bit_valid) begin
            sr <= sr_next;
            case (state)
               HUNT: begin
                  if (sync_hit) begin
                     state    <= PAYLOAD;
                     bit_cnt  <= '0;
                     word_cnt <= '0;
                     locked   <= 1'b1;
                  end
               end
               PAYLOAD: begin
                  if (bit_cnt == LAST_BIT) begin
                     bit_cnt <= '0;
                     if (word_cnt == LAST_WORD) begin
                        word_cnt <= '0;
                        state    <= CHECK;
                     end else begin
                        word_cnt <= word_cnt + 8'd1;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + BW'(1);
                  end
               end
               CHECK: begin
                  if (check_done) begin
                     bit_cnt <= '0;
                     if (sync_hit) begin
                        miss_cnt <= '0;
                        frame_ok <= 1'b1;
                        state    <= PAYLOAD;
                     end else if (miss_room) begin
                        miss_cnt <= miss_cnt + 3'd1;
                        state    <= PAYLOAD;
                     end else begin
                        // Back to hunting with every counter cleared.
                        miss_cnt <= '0;
                        word_cnt <= '0;
                        locked   <= 1'b0;
                        state    <= HUNT;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + BW'(1);
                  end
               end
               default: begin
                  state  <= HUNT;
                  locked <= 1'b0;
               end
            endcase
         end
      end
   end

   rx_out_reg #(
      .N(N)
   ) u_out_reg (
      .clk      (clk),
      .rst      (rst),
      .load     (word_done),
      .data_in  (sr_next),
      .ready    (bus.word_ready),
      .data_out (bus.word_out),
      .valid    (bus.word_valid),
      .overflow (overflow)
   );

`ifdef RX_FRAMER_STATS_EN
   // Statistics counters, stepped by the same decisions the FSM takes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         frame_cnt <= '0;
         loss_cnt  <= '0;
      end else if (check_done) begin
         if (sync_hit) begin
            frame_cnt <= sat_inc16(frame_cnt);
         end else if (!miss_room) begin
            loss_cnt <= sat_inc16(loss_cnt);
         end
      end
   end
`endif

endmodule

// File: tb/tb_rx_word_framer.sv
// Directed self-checking bench for rx_word_framer with default parameters.
// Walks through reset, acquisition, steady state, backpressure, loss of lock
// and mid-frame reset, checking outputs 1 time unit after each active edge.

module tb_rx_word_framer;

   localparam logic [23:0] SYNC = 24'hB4C3A5;

   logic clk;
   logic rst;
   logic locked;
   logic frame_ok;
   logic overflow;
`ifdef RX_FRAMER_STATS_EN
   logic [15:0] frame_cnt;
   logic [15:0] loss_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   rx_word_framer_if #(.N(24)) bus ();

   rx_word_framer dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .locked   (locked),
      .frame_ok (frame_ok),
      .overflow (overflow)
`ifdef RX_FRAMER_STATS_EN
      ,
      .frame_cnt(frame_cnt),
      .loss_cnt (loss_cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Bound on total run time in case the stimulus ever stalls.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      n_checks++;
      assert (observed === expected)
      else begin
         n_fail++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic sendBit(input logic b);
      bus.bit_in    = b;
      bus.bit_valid = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic idleCycles(input int n);
      bus.bit_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Sends one 24-bit word, MSB first, back to back.
   task automatic applyStimulus(input logic [23:0] w);
      for (int i = 23; i >= 0; i--) sendBit(w[i]);
   endtask

   task automatic sendWordExpectOut(input string tag, input logic [23:0] w);
      applyStimulus(w);
      checkOutput({tag, " word_valid"}, {31'd0, bus.word_valid}, 32'd1);
      checkOutput({tag, " word_out"}, {8'd0, bus.word_out}, {8'd0, w});
      checkOutput({tag, " frame_ok"}, {31'd0, frame_ok}, 32'd0);
   endtask

   task automatic sendGoodFrame(input string tag);
      applyStimulus(SYNC);
      checkOutput({tag, " sync frame_ok"}, {31'd0, frame_ok}, 32'd1);
      checkOutput({tag, " sync locked"}, {31'd0, locked}, 32'd1);
      sendWordExpectOut({tag, " w0"}, 24'h000001);
      sendWordExpectOut({tag, " w1"}, 24'h123456);
      sendWordExpectOut({tag, " w2"}, 24'hFFFFFF);
      sendWordExpectOut({tag, " w3"}, 24'hABCDEF);
   endtask

   task automatic sendBadFrame(input string tag);
      applyStimulus(24'h000000);
      checkOutput({tag, " bad sync locked"}, {31'd0, locked}, 32'd1);
      checkOutput({tag, " bad sync frame_ok"}, {31'd0, frame_ok}, 32'd0);
      sendWordExpectOut({tag, " w0"}, 24'h000001);
      sendWordExpectOut({tag, " w1"}, 24'h123456);
      sendWordExpectOut({tag, " w2"}, 24'hFFFFFF);
      sendWordExpectOut({tag, " w3"}, 24'hABCDEF);
   endtask

   initial begin
      logic [6:0]  junk;
      logic [23:0] partial;

      rst            = 1'b0;
      bus.bit_in     = 1'b0;
      bus.bit_valid  = 1'b0;
      bus.word_ready = 1'b1;

      // Reset then idle
      #12;
      checkOutput("in reset locked", {31'd0, locked}, 32'd0);
      checkOutput("in reset word_valid", {31'd0, bus.word_valid}, 32'd0);
      rst = 1'b1;
      idleCycles(3);
      checkOutput("idle locked", {31'd0, locked}, 32'd0);
      checkOutput("idle word_valid", {31'd0, bus.word_valid}, 32'd0);
      checkOutput("idle word_out", {8'd0, bus.word_out}, 32'd0);
      checkOutput("idle frame_ok", {31'd0, frame_ok}, 32'd0);
      checkOutput("idle overflow", {31'd0, overflow}, 32'd0);

      // Acquisition: junk bits, sync (no frame_ok on first match), 4 words
      $display("[TB] acquisition");
      junk = 7'b1010011;
      for (int i = 6; i >= 0; i--) sendBit(junk[i]);
      checkOutput("pre-sync locked", {31'd0, locked}, 32'd0);
      applyStimulus(SYNC);
      checkOutput("acq locked", {31'd0, locked}, 32'd1);
      checkOutput("acq frame_ok", {31'd0, frame_ok}, 32'd0);
      checkOutput("acq word_valid", {31'd0, bus.word_valid}, 32'd0);
      sendWordExpectOut("acq w0", 24'h000001);
      sendWordExpectOut("acq w1", 24'h123456);
      sendWordExpectOut("acq w2", 24'hFFFFFF);
      sendWordExpectOut("acq w3", 24'hABCDEF);

      // Steady state: two good frames
      $display("[TB] steady state");
      sendGoodFrame("steady1");
      sendGoodFrame("steady2");
      checkOutput("steady overflow", {31'd0, overflow}, 32'd0);
      idleCycles(1);
      checkOutput("frame_ok one cycle", {31'd0, frame_ok}, 32'd0);
      checkOutput("handshake clears valid", {31'd0, bus.word_valid}, 32'd0);

      // Backpressure: second word dropped while first is held
      $display("[TB] backpressure");
      applyStimulus(SYNC);
      checkOutput("bp sync frame_ok", {31'd0, frame_ok}, 32'd1);
      bus.word_ready = 1'b0;
      applyStimulus(24'h000001);
      checkOutput("bp first valid", {31'd0, bus.word_valid}, 32'd1);
      checkOutput("bp first data", {8'd0, bus.word_out}, 32'h000001);
      checkOutput("bp first overflow", {31'd0, overflow}, 32'd0);
      applyStimulus(24'h123456);
      checkOutput("bp held valid", {31'd0, bus.word_valid}, 32'd1);
      checkOutput("bp held data", {8'd0, bus.word_out}, 32'h000001);
      checkOutput("bp overflow set", {31'd0, overflow}, 32'd1);
      bus.word_ready = 1'b1;
      idleCycles(1);
      checkOutput("bp drained valid", {31'd0, bus.word_valid}, 32'd0);
      checkOutput("bp overflow sticky", {31'd0, overflow}, 32'd1);
      sendWordExpectOut("bp w2", 24'hFFFFFF);
      sendWordExpectOut("bp w3", 24'hABCDEF);

      // Loss of lock: two flywheeled frames, third bad sync drops lock
      $display("[TB] loss of lock");
      sendBadFrame("miss1");
      sendBadFrame("miss2");
      applyStimulus(24'h000000);
      checkOutput("miss3 locked", {31'd0, locked}, 32'd0);
      checkOutput("miss3 frame_ok", {31'd0, frame_ok}, 32'd0);
      applyStimulus(24'h000000);
      checkOutput("hunt no word", {31'd0, bus.word_valid}, 32'd0);
      checkOutput("hunt locked", {31'd0, locked}, 32'd0);
      applyStimulus(SYNC);
      checkOutput("reacq locked", {31'd0, locked}, 32'd1);
      checkOutput("reacq frame_ok", {31'd0, frame_ok}, 32'd0);
      sendWordExpectOut("reacq w0", 24'h000001);
`ifdef RX_FRAMER_STATS_EN
      checkOutput("stats frame_cnt", {16'd0, frame_cnt}, 32'd3);
      checkOutput("stats loss_cnt", {16'd0, loss_cnt}, 32'd1);
`endif

      // Mid-frame reset after 10 payload bits
      $display("[TB] mid-frame reset");
      partial = 24'hABCDEF;
      for (int i = 23; i >= 14; i--) sendBit(partial[i]);
      bus.bit_valid = 1'b0;
      rst = 1'b0;
      #2;
      checkOutput("mid rst word_valid", {31'd0, bus.word_valid}, 32'd0);
      checkOutput("mid rst locked", {31'd0, locked}, 32'd0);
      checkOutput("mid rst overflow", {31'd0, overflow}, 32'd0);
      checkOutput("mid rst word_out", {8'd0, bus.word_out}, 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      applyStimulus(SYNC);
      checkOutput("post rst locked", {31'd0, locked}, 32'd1);
      checkOutput("post rst frame_ok", {31'd0, frame_ok}, 32'd0);
      sendWordExpectOut("post rst w0", 24'h123456);
      sendWordExpectOut("post rst w1", 24'hABCDEF);

      idleCycles(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
